// File: rtl/wd_rst_stretcher_if.sv
// -----------------------------------------------------------------------------
// wd_rst_stretcher_if
//
// Purpose:
//   Bundles the watchdog-fail inputs, the pulse configuration and the reset /
//   status outputs of wd_rst_stretcher into one interface. Clock and reset stay
//   plain ports on the design so the interface carries only functional signals.
//
// Parameters:
//   WIDTH  width of RST_LMT, HOLDOFF and the internal down-counter
//   N_CH   number of watchdog-fail channels
//   CNT_W  width of the saturating fail-event counter
//
// Signals:
//   WDFAIL    [N_CH]   per-channel watchdog fail level
//   CH_EN     [N_CH]   per-channel monitor enable (1 = monitored)
//   RST_LMT   [WIDTH]  reset pulse length in cycles, taken at load
//   HOLDOFF   [WIDTH]  post-pulse ignore window in cycles, taken at load
//   RETRIG    [1]      accepted fail during the pulse reloads the pulse counter
//   RSTOUT    [1]      registered reset pulse
//   BUSY      [1]      high while the pulse or hold-off window is running
//   FAIL_SRC  [N_CH]   channels that started or extended the current/last pulse
//   FAIL_CNT  [CNT_W]  accepted fail events, saturating
//   LMT_ERR   [1]      sticky: a fail rise arrived while RST_LMT was zero
//
// Modports:
//   master  drives the inputs, observes the outputs (watchdog / system side)
//   slave   the stretcher itself
// -----------------------------------------------------------------------------
interface wd_rst_stretcher_if #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned N_CH  = 4,
   parameter int unsigned CNT_W = 8
);

   logic [N_CH-1:0]  WDFAIL;
   logic [N_CH-1:0]  CH_EN;
   logic [WIDTH-1:0] RST_LMT;
   logic [WIDTH-1:0] HOLDOFF;
   logic             RETRIG;
   logic             RSTOUT;
   logic             BUSY;
   logic [N_CH-1:0]  FAIL_SRC;
   logic [CNT_W-1:0] FAIL_CNT;
   logic             LMT_ERR;

   modport master (
      output WDFAIL,
      output CH_EN,
      output RST_LMT,
      output HOLDOFF,
      output RETRIG,
      input  RSTOUT,
      input  BUSY,
      input  FAIL_SRC,
      input  FAIL_CNT,
      input  LMT_ERR
   );

   modport slave (
      input  WDFAIL,
      input  CH_EN,
      input  RST_LMT,
      input  HOLDOFF,
      input  RETRIG,
      output RSTOUT,
      output BUSY,
      output FAIL_SRC,
      output FAIL_CNT,
      output LMT_ERR
   );

endinterface

// File: rtl/wd_rst_stretcher.sv
// -----------------------------------------------------------------------------
// wd_rst_stretcher
//
// Purpose:
//   Multi-channel watchdog reset generator. Each enabled watchdog-fail line is
//   edge detected; an accepted rise starts a reset pulse of RST_LMT cycles,
//   followed by an optional HOLDOFF window during which new rises are ignored.
//   With RETRIG set, a rise during the pulse reloads the pulse counter. The
//   channels that caused the pulse and a saturating event count are recorded.
//
// Ports:
//   CLK   system clock, everything on the rising edge
//   RST   synchronous active-high reset
//   bus   wd_rst_stretcher_if.slave
//           in : WDFAIL, CH_EN, RST_LMT, HOLDOFF, RETRIG
//           out: RSTOUT, BUSY, FAIL_SRC, FAIL_CNT, LMT_ERR (all registered)
//
// Timing:
//   The rise is sampled on edge E0; RSTOUT is high after E0 for exactly
//   RST_LMT cycles. With HOLDOFF = H != 0, BUSY stays high for H more cycles
//   after RSTOUT falls. A rise sampled on the first edge after BUSY falls is
//   accepted again.
// -----------------------------------------------------------------------------
module wd_rst_stretcher #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned N_CH  = 4,
   parameter int unsigned CNT_W = 8
) (
   input logic             CLK,
   input logic             RST,
   wd_rst_stretcher_if.slave bus
);

   typedef enum logic [1:0] {
      StIdle,
      StActive,
      StHold
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [N_CH-1:0]  prev_q;
   logic             rstout_q, rstout_d;
   logic             busy_q, busy_d;
   logic [N_CH-1:0]  src_q, src_d;
   logic [CNT_W-1:0] fcnt_q, fcnt_d;
   logic             lmt_err_q, lmt_err_d;

   logic [N_CH-1:0]  masked;
   logic [N_CH-1:0]  rise;
   logic             trig;
   logic             lmt_zero;
   logic             hold_zero;
   logic             cnt_last;
   logic [CNT_W-1:0] fcnt_inc;

   // Edge detection runs in every state, so a level that stays high through
   // the pulse or hold-off does not fire again when the FSM returns to idle.
   assign masked    = bus.WDFAIL & bus.CH_EN;
   assign rise      = masked & ~prev_q;
   assign trig      = |rise;

   assign lmt_zero  = (bus.RST_LMT == '0);
   assign hold_zero = (bus.HOLDOFF == '0);
   assign cnt_last  = (cnt_q == WIDTH'(1));

   // Saturating increment: stick at all-ones instead of wrapping.
   assign fcnt_inc  = (fcnt_q == '1) ? fcnt_q : fcnt_q + CNT_W'(1);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rstout_d  = rstout_q;
      src_d     = src_q;
      fcnt_d    = fcnt_q;
      lmt_err_d = lmt_err_q;

      unique case (state_q)
         StIdle: begin
            rstout_d = 1'b0;
            if (trig) begin
               if (!lmt_zero) begin
                  state_d  = StActive;
                  cnt_d    = bus.RST_LMT;
                  rstout_d = 1'b1;
                  src_d    = rise;
                  fcnt_d   = fcnt_inc;
               end else begin
                  lmt_err_d = 1'b1;
               end
            end
         end

         StActive: begin
            if (bus.RETRIG && trig && !lmt_zero) begin
               // Retrigger wins over the end-of-pulse check, even at cnt == 1.
               cnt_d    = bus.RST_LMT;
               rstout_d = 1'b1;
               src_d    = src_q | rise;
               fcnt_d   = fcnt_inc;
            end else begin
               // A retrigger attempt with a zero limit is flagged, then the
               // pulse carries on as if nothing happened.
               if (bus.RETRIG && trig) begin
                  lmt_err_d = 1'b1;
               end
               if (cnt_last) begin
                  rstout_d = 1'b0;
                  if (!hold_zero) begin
                     state_d = StHold;
                     cnt_d   = bus.HOLDOFF;
                  end else begin
                     state_d = StIdle;
                     cnt_d   = '0;
                  end
               end else begin
                  cnt_d = cnt_q - WIDTH'(1);
               end
            end
         end

         StHold: begin
            rstout_d = 1'b0;
            if (cnt_last) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - WIDTH'(1);
            end
         end

         default: begin
            state_d  = StIdle;
            cnt_d    = '0;
            rstout_d = 1'b0;
         end
      endcase

      // Registered alongside state so BUSY lines up with the FSM.
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         prev_q    <= '0;
         rstout_q  <= 1'b0;
         busy_q    <= 1'b0;
         src_q     <= '0;
         fcnt_q    <= '0;
         lmt_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         prev_q    <= masked;
         rstout_q  <= rstout_d;
         busy_q    <= busy_d;
         src_q     <= src_d;
         fcnt_q    <= fcnt_d;
         lmt_err_q <= lmt_err_d;
      end
   end

   assign bus.RSTOUT   = rstout_q;
   assign bus.BUSY     = busy_q;
   assign bus.FAIL_SRC = src_q;
   assign bus.FAIL_CNT = fcnt_q;
   assign bus.LMT_ERR  = lmt_err_q;

endmodule

// File: tb/tb_wd_rst_stretcher.sv
// -----------------------------------------------------------------------------
// tb_wd_rst_stretcher
//
// Cycle-by-cycle vector table for the basic FSM and edge-detect behaviour,
// then scheduled multi-cycle sequences for pulse length, retrigger, hold-off,
// masking, zero limit, saturation and mid-pulse reset. A second instance with
// CNT_W = 2 shares the stimulus and is used for the saturation check.
// -----------------------------------------------------------------------------
module tb_wd_rst_stretcher;

   logic CLK;
   logic rst;

   int checks   = 0;
   int failures = 0;

   wd_rst_stretcher_if #(.WIDTH(16), .N_CH(4), .CNT_W(8)) bus ();
   wd_rst_stretcher_if #(.WIDTH(16), .N_CH(4), .CNT_W(2)) sat_bus ();

   wd_rst_stretcher #(.WIDTH(16), .N_CH(4), .CNT_W(8)) dut (
      .CLK (CLK),
      .RST (rst),
      .bus (bus)
   );

   wd_rst_stretcher #(.WIDTH(16), .N_CH(4), .CNT_W(2)) dut_sat (
      .CLK (CLK),
      .RST (rst),
      .bus (sat_bus)
   );

   assign sat_bus.WDFAIL  = bus.WDFAIL;
   assign sat_bus.CH_EN   = bus.CH_EN;
   assign sat_bus.RST_LMT = bus.RST_LMT;
   assign sat_bus.HOLDOFF = bus.HOLDOFF;
   assign sat_bus.RETRIG  = bus.RETRIG;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic        rst;
      logic [3:0]  wd;
      logic [3:0]  en;
      logic [15:0] lmt;
      logic [15:0] hold;
      logic        rs;
      logic        bz;
      logic [3:0]  src;
      logic [7:0]  cnt;
      logic        err;
   } vec_t;

   localparam int NVEC = 19;
   vec_t tbl [NVEC];

   logic [3:0] sched_wd  [64];
   logic       sched_rst [64];
   logic       rs_log    [64];
   logic       bz_log    [64];
   logic [3:0] src_log   [64];
   logic [7:0] cnt_log   [64];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge CLK);
      rst = 1'b1;
      bus.WDFAIL = 4'h0;
      repeat (2) @(posedge CLK);
   endtask

   task automatic clr_sched();
      for (int i = 0; i < 64; i++) begin
         sched_wd[i]  = 4'h0;
         sched_rst[i] = 1'b0;
      end
   endtask

   task automatic run(input int n);
      for (int c = 0; c < n; c++) begin
         @(negedge CLK);
         bus.WDFAIL = sched_wd[c];
         rst        = sched_rst[c];
         @(posedge CLK);
         #1;
         rs_log[c]  = bus.RSTOUT;
         bz_log[c]  = bus.BUSY;
         src_log[c] = bus.FAIL_SRC;
         cnt_log[c] = bus.FAIL_CNT;
      end
   endtask

   function automatic int rs_hi(input int lo, input int hi);
      int n = 0;
      for (int i = lo; i <= hi; i++) if (rs_log[i]) n++;
      return n;
   endfunction

   function automatic int bz_hi(input int lo, input int hi);
      int n = 0;
      for (int i = lo; i <= hi; i++) if (bz_log[i]) n++;
      return n;
   endfunction

   initial begin
      rst         = 1'b1;
      bus.WDFAIL  = 4'h0;
      bus.CH_EN   = 4'hF;
      bus.RST_LMT = 16'd3;
      bus.HOLDOFF = 16'd2;
      bus.RETRIG  = 1'b0;

      //           rst  wd    en    lmt    hold   rs    bz    src   cnt   err
      tbl[0]  = '{1'b1, 4'h0, 4'hF, 16'd3, 16'd2, 1'b0, 1'b0, 4'h0, 8'd0, 1'b0};
      tbl[1]  = '{1'b0, 4'h0, 4'hF, 16'd3, 16'd2, 1'b0, 1'b0, 4'h0, 8'd0, 1'b0};
      tbl[2]  = '{1'b0, 4'h1, 4'hF, 16'd3, 16'd2, 1'b1, 1'b1, 4'h1, 8'd1, 1'b0};
      tbl[3]  = '{1'b0, 4'h1, 4'hF, 16'd3, 16'd2, 1'b1, 1'b1, 4'h1, 8'd1, 1'b0};
      tbl[4]  = '{1'b0, 4'h0, 4'hF, 16'd3, 16'd2, 1'b1, 1'b1, 4'h1, 8'd1, 1'b0};
      tbl[5]  = '{1'b0, 4'h0, 4'hF, 16'd3, 16'd2, 1'b0, 1'b1, 4'h1, 8'd1, 1'b0};
      tbl[6]  = '{1'b0, 4'h2, 4'hF, 16'd3, 16'd2, 1'b0, 1'b1, 4'h1, 8'd1, 1'b0};
      tbl[7]  = '{1'b0, 4'h2, 4'hF, 16'd3, 16'd2, 1'b0, 1'b0, 4'h1, 8'd1, 1'b0};
      tbl[8]  = '{1'b0, 4'h2, 4'hF, 16'd3, 16'd2, 1'b0, 1'b0, 4'h1, 8'd1, 1'b0};
      tbl[9]  = '{1'b0, 4'h2, 4'h0, 16'd3, 16'd2, 1'b0, 1'b0, 4'h1, 8'd1, 1'b0};
      tbl[10] = '{1'b0, 4'h2, 4'hF, 16'd3, 16'd2, 1'b1, 1'b1, 4'h2, 8'd2, 1'b0};
      tbl[11] = '{1'b0, 4'h2, 4'hF, 16'd0, 16'd2, 1'b1, 1'b1, 4'h2, 8'd2, 1'b0};
      tbl[12] = '{1'b0, 4'h2, 4'hF, 16'd0, 16'd2, 1'b1, 1'b1, 4'h2, 8'd2, 1'b0};
      tbl[13] = '{1'b0, 4'h2, 4'hF, 16'd0, 16'd2, 1'b0, 1'b1, 4'h2, 8'd2, 1'b0};
      tbl[14] = '{1'b0, 4'h2, 4'hF, 16'd0, 16'd2, 1'b0, 1'b1, 4'h2, 8'd2, 1'b0};
      tbl[15] = '{1'b0, 4'h2, 4'hF, 16'd0, 16'd2, 1'b0, 1'b0, 4'h2, 8'd2, 1'b0};
      tbl[16] = '{1'b0, 4'h3, 4'hF, 16'd0, 16'd2, 1'b0, 1'b0, 4'h2, 8'd2, 1'b1};
      tbl[17] = '{1'b0, 4'h0, 4'hF, 16'd3, 16'd2, 1'b0, 1'b0, 4'h2, 8'd2, 1'b1};
      tbl[18] = '{1'b1, 4'h0, 4'hF, 16'd3, 16'd2, 1'b0, 1'b0, 4'h0, 8'd0, 1'b0};

      for (int i = 0; i < NVEC; i++) begin
         @(negedge CLK);
         rst         = tbl[i].rst;
         bus.WDFAIL  = tbl[i].wd;
         bus.CH_EN   = tbl[i].en;
         bus.RST_LMT = tbl[i].lmt;
         bus.HOLDOFF = tbl[i].hold;
         @(posedge CLK);
         #1;
         check($sformatf("vec%0d.rstout", i), 32'(bus.RSTOUT), 32'(tbl[i].rs));
         check($sformatf("vec%0d.busy", i), 32'(bus.BUSY), 32'(tbl[i].bz));
         check($sformatf("vec%0d.fail_src", i), 32'(bus.FAIL_SRC), 32'(tbl[i].src));
         check($sformatf("vec%0d.fail_cnt", i), 32'(bus.FAIL_CNT), 32'(tbl[i].cnt));
         check($sformatf("vec%0d.lmt_err", i), 32'(bus.LMT_ERR), 32'(tbl[i].err));
      end

      // 10-cycle pulse from an 8-cycle fail level, no hold-off.
      bus.CH_EN = 4'hF; bus.RST_LMT = 16'd10; bus.HOLDOFF = 16'd0; bus.RETRIG = 1'b0;
      do_reset();
      clr_sched();
      for (int c = 0; c < 8; c++) sched_wd[c] = 4'h1;
      run(30);
      check("t1.first_high", 32'(rs_log[0]), 32'd1);
      check("t1.pulse_len", 32'(rs_hi(0, 29)), 32'd10);
      check("t1.last_high", 32'(rs_log[9]), 32'd1);
      check("t1.busy_len", 32'(bz_hi(0, 29)), 32'd10);
      check("t1.busy_drop", 32'(bz_log[10]), 32'd0);
      check("t1.fail_src", 32'(bus.FAIL_SRC), 32'h1);
      check("t1.fail_cnt", 32'(bus.FAIL_CNT), 32'd1);

      // Retrigger on channel 2, six cycles into the pulse.
      bus.RETRIG = 1'b1;
      do_reset();
      clr_sched();
      for (int c = 0; c < 6; c++) sched_wd[c] = 4'h1;
      sched_wd[6] = 4'h5;
      sched_wd[7] = 4'h5;
      run(40);
      check("t2a.pulse_len", 32'(rs_hi(0, 39)), 32'd16);
      check("t2a.last_high", 32'(rs_log[15]), 32'd1);
      check("t2a.fail_src", 32'(bus.FAIL_SRC), 32'h5);
      check("t2a.fail_cnt", 32'(bus.FAIL_CNT), 32'd2);

      bus.RETRIG = 1'b0;
      do_reset();
      run(40);
      check("t2b.pulse_len", 32'(rs_hi(0, 39)), 32'd10);
      check("t2b.fail_src", 32'(bus.FAIL_SRC), 32'h1);
      check("t2b.fail_cnt", 32'(bus.FAIL_CNT), 32'd1);

      // Hold-off window swallows a rise, next rise after BUSY falls is taken.
      bus.RST_LMT = 16'd4; bus.HOLDOFF = 16'd5;
      do_reset();
      clr_sched();
      sched_wd[0]  = 4'h1;
      sched_wd[6]  = 4'h1;
      sched_wd[7]  = 4'h1;
      sched_wd[10] = 4'h1;
      run(30);
      check("t3.first_pulse", 32'(rs_hi(0, 9)), 32'd4);
      check("t3.hold_no_pulse", 32'(rs_hi(4, 9)), 32'd0);
      check("t3.hold_busy", 32'(bz_hi(4, 8)), 32'd5);
      check("t3.busy_low", 32'(bz_log[9]), 32'd0);
      check("t3.cnt_in_hold", 32'(cnt_log[8]), 32'd1);
      check("t3.second_start", 32'(rs_log[10]), 32'd1);
      check("t3.second_pulse", 32'(rs_hi(10, 29)), 32'd4);
      check("t3.second_busy", 32'(bz_hi(10, 29)), 32'd9);
      check("t3.fail_cnt", 32'(bus.FAIL_CNT), 32'd2);

      // Masked channel ignored; two simultaneous rises are one event.
      bus.CH_EN = 4'hE; bus.HOLDOFF = 16'd0;
      do_reset();
      clr_sched();
      for (int c = 0; c < 5; c++) sched_wd[c] = 4'h1;
      for (int c = 5; c < 8; c++) sched_wd[c] = 4'hB;
      run(30);
      check("t4.masked_no_pulse", 32'(rs_hi(0, 4)), 32'd0);
      check("t4.start", 32'(rs_log[5]), 32'd1);
      check("t4.pulse_len", 32'(rs_hi(5, 29)), 32'd4);
      check("t4.fail_src", 32'(bus.FAIL_SRC), 32'hA);
      check("t4.fail_cnt", 32'(bus.FAIL_CNT), 32'd1);

      // Zero limit: no pulse, sticky error until reset.
      bus.CH_EN = 4'hF; bus.RST_LMT = 16'd0;
      do_reset();
      clr_sched();
      for (int c = 0; c < 3; c++) sched_wd[c] = 4'h1;
      run(6);
      check("t5a.no_pulse", 32'(rs_hi(0, 5)), 32'd0);
      check("t5a.lmt_err", 32'(bus.LMT_ERR), 32'd1);
      check("t5a.fail_cnt", 32'(bus.FAIL_CNT), 32'd0);
      bus.RST_LMT = 16'd4;
      clr_sched();
      sched_wd[0] = 4'h2;
      run(10);
      check("t5a.later_pulse", 32'(rs_hi(0, 9)), 32'd4);
      check("t5a.lmt_err_held", 32'(bus.LMT_ERR), 32'd1);
      do_reset();
      clr_sched();
      run(2);
      check("t5a.lmt_err_rst", 32'(bus.LMT_ERR), 32'd0);

      // Five one-cycle events: 8-bit count reaches 5, 2-bit count sticks at 3.
      bus.RST_LMT = 16'd1;
      do_reset();
      clr_sched();
      for (int c = 0; c < 10; c += 2) sched_wd[c] = 4'h1;
      run(14);
      check("t5b.pulses", 32'(rs_hi(0, 13)), 32'd5);
      check("t5b.fail_cnt", 32'(bus.FAIL_CNT), 32'd5);
      check("t5b.sat_cnt", 32'(sat_bus.FAIL_CNT), 32'd3);

      // Reset mid-pulse with the fail level held across release.
      bus.RST_LMT = 16'd10;
      do_reset();
      clr_sched();
      for (int c = 0; c < 20; c++) sched_wd[c] = 4'h1;
      sched_rst[3] = 1'b1;
      run(20);
      check("t6.before_rst", 32'(rs_hi(0, 2)), 32'd3);
      check("t6.rst_rstout", 32'(rs_log[3]), 32'd0);
      check("t6.rst_busy", 32'(bz_log[3]), 32'd0);
      check("t6.rst_src", 32'(src_log[3]), 32'h0);
      check("t6.rst_cnt", 32'(cnt_log[3]), 32'd0);
      check("t6.refire", 32'(rs_log[4]), 32'd1);
      check("t6.refire_len", 32'(rs_hi(4, 19)), 32'd10);
      check("t6.fail_cnt", 32'(bus.FAIL_CNT), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wd_rst_stretcher.md
Name: wd_rst_stretcher

Overview:
Parametrised multi-channel watchdog reset generator. It monitors N_CH watchdog-fail lines and, on an accepted fail event, drives a reset pulse of programmable length. It then applies a programmable hold-off window. It optionally retriggers on new fails during the pulse, and records which channels caused the pulse along with a saturating fail count. It sits between the watchdog timers and the system reset distribution.

Parameters:
WIDTH, 16, width of RST_LMT, HOLDOFF and the internal down-counter
N_CH, 4, number of watchdog-fail input channels
CNT_W, 8, width of the saturating fail-event counter

Ports:
CLK  in  1  system clock, all logic on rising edge
RST  in  1  synchronous active-high reset
WDFAIL  in  N_CH  per-channel watchdog fail, level
CH_EN  in  N_CH  per-channel enable mask (1 = monitored)
RST_LMT  in  WIDTH  reset pulse length in cycles, sampled at load
HOLDOFF  in  WIDTH  post-pulse ignore window in cycles, sampled at load
RETRIG  in  1  1 = accepted fail during pulse reloads the pulse counter
RSTOUT  out  1  registered reset pulse to the system
BUSY  out  1  high in ACTIVE or HOLD
FAIL_SRC  out  N_CH  channels that triggered or retriggered the current/last pulse
FAIL_CNT  out  CNT_W  accepted fail events, saturating
LMT_ERR  out  1  registered flag: a fail rise arrived while RST_LMT == 0

Behaviour:
- Reset values (RST high at a rising edge): RSTOUT=0, BUSY=0, FAIL_SRC=0, FAIL_CNT=0, LMT_ERR=0, state=IDLE, cnt=0, prev=0.
- Edge detect:
  - masked = WDFAIL & CH_EN; prev <= masked every cycle.
  - rise = masked & ~prev; trig = |rise.
  - A level held high triggers once only.
  - After RST releases, prev=0, so a line already high counts as a rise on the first edge.
  - Clearing CH_EN then setting it while WDFAIL is high produces a new rise.
- FSM states: IDLE, ACTIVE, HOLD. All outputs are registered.
- IDLE:
  - If trig and RST_LMT != 0: go to ACTIVE, cnt <= RST_LMT, RSTOUT <= 1, FAIL_SRC <= rise, FAIL_CNT += 1.
  - If trig and RST_LMT == 0: stay in IDLE, LMT_ERR <= 1 (sticky until RST). No pulse, no count.
- ACTIVE:
  - RSTOUT=1 for exactly RST_LMT cycles, counted from the edge after the sampling edge. cnt decrements each cycle.
  - When cnt==1 with no retrigger: RSTOUT <= 0. If HOLDOFF != 0, go to HOLD with cnt <= HOLDOFF; else go to IDLE.
  - If RETRIG=1 and trig (any cycle, including cnt==1): cnt <= RST_LMT, FAIL_SRC <= FAIL_SRC | rise, FAIL_CNT += 1, RSTOUT stays 1. If RST_LMT==0 at that moment, the retrigger is ignored and LMT_ERR <= 1.
  - If RETRIG=0: rises are ignored, not counted, and not recorded.
- HOLD:
  - RSTOUT=0, BUSY=1; cnt decrements each cycle; at cnt==1 go to IDLE.
  - Rises in HOLD are ignored and not counted. prev still updates, so a level that stays high does not fire on return to IDLE.
- BUSY=1 exactly when state is ACTIVE or HOLD (registered alongside state).
- FAIL_SRC is held after the pulse ends, until the next IDLE->ACTIVE load or RST.
- FAIL_CNT saturates at 2^CNT_W-1 with no wrap.
- RST_LMT, HOLDOFF and RETRIG may change at any time. RST_LMT and HOLDOFF take effect only at load. RETRIG is evaluated every cycle.
- RST asserted mid-pulse: all state returns to reset values at that edge, and RSTOUT=0 from the next cycle.
- Multiple simultaneous rises are one event: FAIL_CNT += 1 and FAIL_SRC gets all of the rise bits.

Test Plan:
1. N_CH=4, CH_EN=4'hF, RST_LMT=10, HOLDOFF=0. Pulse WDFAIL[0] high for 8 cycles -> RSTOUT high for exactly 10 cycles, starting one edge after the rise is sampled. FAIL_SRC=4'b0001, FAIL_CNT=1, BUSY drops with RSTOUT.
2. RETRIG=1, RST_LMT=10. Rise on WDFAIL[2] 6 cycles into the pulse -> RSTOUT total 16 cycles, FAIL_SRC=4'b0101, FAIL_CNT=2. Repeat with RETRIG=0 -> 10 cycles, FAIL_SRC=4'b0001, FAIL_CNT=1.
3. HOLDOFF=5, RST_LMT=4. Second rise 2 cycles after RSTOUT falls -> no pulse, BUSY high for 5 cycles, FAIL_CNT unchanged. A rise 1 cycle after BUSY falls -> new 4-cycle pulse.
4. CH_EN=4'b1110, WDFAIL[0] rises -> no pulse. Then WDFAIL[1] and WDFAIL[3] rise on the same edge -> one pulse, FAIL_SRC=4'b1010, FAIL_CNT=1.
5. RST_LMT=0, WDFAIL[0] rises -> RSTOUT stays 0, LMT_ERR=1 and held until RST. Also: CNT_W=2 with 5 separate events -> FAIL_CNT=3.
6. RST asserted at cycle 3 of a 10-cycle pulse -> next cycle RSTOUT=0, BUSY=0, FAIL_SRC=0, FAIL_CNT=0. WDFAIL held high across RST release -> a new pulse fires one edge after release.
